// File: rtl/sgmii_rx_sync_pkg.sv
// Shared constants and types for the SGMII receive synchroniser.
package sgmii_pcs_pkg;

    localparam logic [7:0] K28_5        = 8'hBC;
    localparam logic [1:0] GOOD_CGS_MAX = 2'd3;

    // Synchronisation states; LOS must stay at encoding 0.
    typedef enum logic [2:0] {
        ST_LOS  = 3'd0,
        ST_ACQ1 = 3'd1,
        ST_ACQ2 = 3'd2,
        ST_SA1  = 3'd3,
        ST_SA2  = 3'd4,
        ST_SA3  = 3'd5,
        ST_SA4  = 3'd6
    } sync_state_e;

    // Bit-slip sequencer phases.
    typedef enum logic [1:0] {
        SLIP_IDLE  = 2'd0,
        SLIP_PULSE = 2'd1,
        SLIP_BLANK = 2'd2
    } slip_phase_e;

    // A comma is an error-free K28.5.
    function automatic logic is_comma(input logic [7:0] cg, input logic ctrl, input logic inv);
        return (cg == K28_5) && ctrl && !inv;
    endfunction

endpackage

// File: rtl/sgmii_rx_sync_if.sv
// Code-group bus between the SERDES/decoder wrapper, the synchroniser and the PCS.
interface sgmii_rx_sync_if;

    logic [7:0] i8_RxCodeGroup;
    logic       i_RxCodeCtrl;
    logic       i_RxCodeInvalid;
    logic       o_RxBitSlip;
    logic [7:0] o8_RxCodeGroup;
    logic       o_RxCodeCtrl;
    logic       o_RxCodeInvalid;
    logic       o_RxEven;
    logic       o_SyncStatus;
    logic [3:0] o4_SlipCnt;

    // Upstream side: supplies decoded code groups, observes the synchroniser.
    modport master (
        output i8_RxCodeGroup, i_RxCodeCtrl, i_RxCodeInvalid,
        input  o_RxBitSlip, o8_RxCodeGroup, o_RxCodeCtrl, o_RxCodeInvalid,
        input  o_RxEven, o_SyncStatus, o4_SlipCnt
    );

    // Synchroniser side.
    modport slave (
        input  i8_RxCodeGroup, i_RxCodeCtrl, i_RxCodeInvalid,
        output o_RxBitSlip, o8_RxCodeGroup, o_RxCodeCtrl, o_RxCodeInvalid,
        output o_RxEven, o_SyncStatus, o4_SlipCnt
    );

endinterface

// File: rtl/sgmii_rx_sync_bitslip_ctrl.sv
// Comma search timer and bit-slip pulse/blanking sequencer with a modulo-10 slip count.
module lvds_bitslip_ctrl
    import sgmii_pcs_pkg::*;
#(
    parameter int unsigned SEARCH_WIN = 64,
    parameter int unsigned SLIP_HIGH  = 2,
    parameter int unsigned SLIP_WAIT  = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       comma_i,
    output logic       slip_o,
    output logic       busy_o,
    output logic [3:0] slip_cnt_o
);

    logic [9:0]  search_q, search_d;
    logic [5:0]  timer_q, timer_d;
    slip_phase_e phase_q, phase_d;
    logic        slip_q, slip_d;
    logic [3:0]  cnt_q, cnt_d;

    // Search timing and slip sequencing; disable aborts everything except the slip count.
    always_comb begin
        search_d = search_q;
        timer_d  = timer_q;
        phase_d  = phase_q;
        slip_d   = slip_q;
        cnt_d    = cnt_q;
        if (!en_i) begin
            search_d = '0;
            timer_d  = '0;
            phase_d  = SLIP_IDLE;
            slip_d   = 1'b0;
        end else begin
            unique case (phase_q)
                SLIP_IDLE: begin
                    if (comma_i) begin
                        search_d = '0;
                    end else if (search_q == 10'(SEARCH_WIN - 1)) begin
                        search_d = '0;
                        phase_d  = SLIP_PULSE;
                        timer_d  = 6'(SLIP_HIGH - 1);
                        slip_d   = 1'b1;
                        cnt_d    = (cnt_q == 4'd9) ? '0 : cnt_q + 4'd1;
                    end else begin
                        search_d = search_q + 10'd1;
                    end
                end
                SLIP_PULSE: begin
                    if (timer_q == '0) begin
                        phase_d = SLIP_BLANK;
                        timer_d = 6'(SLIP_WAIT - 1);
                        slip_d  = 1'b0;
                    end else begin
                        timer_d = timer_q - 6'd1;
                    end
                end
                SLIP_BLANK: begin
                    if (timer_q == '0) begin
                        phase_d  = SLIP_IDLE;
                        search_d = '0;
                    end else begin
                        timer_d = timer_q - 6'd1;
                    end
                end
                default: begin
                    phase_d = SLIP_IDLE;
                    slip_d  = 1'b0;
                end
            endcase
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            search_q <= '0;
            timer_q  <= '0;
            phase_q  <= SLIP_IDLE;
            slip_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            search_q <= search_d;
            timer_q  <= timer_d;
            phase_q  <= phase_d;
            slip_q   <= slip_d;
            cnt_q    <= cnt_d;
        end
    end

    assign slip_o     = slip_q;
    assign busy_o     = (phase_q != SLIP_IDLE);
    assign slip_cnt_o = cnt_q;

endmodule

// File: rtl/sgmii_rx_sync.sv
// SGMII receive code-group synchroniser: comma search with bit-slip, sync FSM, slot parity.
module sgmii_rx_sync
    import sgmii_pcs_pkg::*;
#(
    parameter int unsigned SEARCH_WIN = 64,
    parameter int unsigned SLIP_HIGH  = 2,
    parameter int unsigned SLIP_WAIT  = 8
) (
    input  logic              i_Clk,
    input  logic              i_ARst_L,
    input  logic              i_PllLocked,
    sgmii_rx_sync_if.slave    rx
);

    sync_state_e state_q, state_d;
    logic [1:0]  good_q, good_d;
    logic        even_q;
    logic [7:0]  cg_q;
    logic        ctrl_q, inv_q;
    logic        sync_status;

    logic comma, los, comma_acc, cur_even, cg_bad;
    logic slip_en, slip_busy, slip_pulse;
    logic [3:0] slip_cnt;

    assign comma     = is_comma(rx.i8_RxCodeGroup, rx.i_RxCodeCtrl, rx.i_RxCodeInvalid);
    assign los       = (state_q == ST_LOS);
    // Commas are ignored while a slip pulse or its blanking window is in progress.
    assign comma_acc = los && comma && !slip_busy;
    // An accepted LOS comma pins the slot to even; otherwise parity alternates.
    assign cur_even  = comma_acc || !even_q;
    assign cg_bad    = rx.i_RxCodeInvalid || (comma && !cur_even);
    assign slip_en   = los && i_PllLocked;

    lvds_bitslip_ctrl #(
        .SEARCH_WIN (SEARCH_WIN),
        .SLIP_HIGH  (SLIP_HIGH),
        .SLIP_WAIT  (SLIP_WAIT)
    ) u_slip (
        .clk_i      (i_Clk),
        .rst_ni     (i_ARst_L),
        .en_i       (slip_en),
        .comma_i    (comma),
        .slip_o     (slip_pulse),
        .busy_o     (slip_busy),
        .slip_cnt_o (slip_cnt)
    );

    // State, good-code-group counter and slot parity registers.
    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            state_q <= ST_LOS;
            good_q  <= '0;
            even_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            even_q  <= cur_even;
        end
    end

    // Next-state logic; a bad code group takes precedence over good_cgs reaching its limit.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (!i_PllLocked) begin
            state_d = ST_LOS;
            good_d  = '0;
        end else begin
            unique case (state_q)
                ST_LOS:  if (comma_acc) state_d = ST_ACQ1;
                ST_ACQ1: begin
                    if (cg_bad)     state_d = ST_LOS;
                    else if (comma) state_d = ST_ACQ2;
                end
                ST_ACQ2: begin
                    if (cg_bad)     state_d = ST_LOS;
                    else if (comma) state_d = ST_SA1;
                end
                ST_SA1: begin
                    if (cg_bad) begin
                        state_d = ST_SA2;
                        good_d  = '0;
                    end
                end
                ST_SA2, ST_SA3, ST_SA4: begin
                    if (cg_bad) begin
                        good_d  = '0;
                        state_d = (state_q == ST_SA2) ? ST_SA3 :
                                  (state_q == ST_SA3) ? ST_SA4 : ST_LOS;
                    end else if (good_q == GOOD_CGS_MAX) begin
                        good_d  = '0;
                        state_d = (state_q == ST_SA4) ? ST_SA3 :
                                  (state_q == ST_SA3) ? ST_SA2 : ST_SA1;
                    end else begin
                        good_d  = good_q + 2'd1;
                    end
                end
                default: begin
                    state_d = ST_LOS;
                    good_d  = '0;
                end
            endcase
        end
    end

    // Sync flag decoded from the registered state so it lines up with the registered data.
    always_comb begin
        sync_status = 1'b0;
        unique case (state_q)
            ST_SA1, ST_SA2, ST_SA3, ST_SA4: sync_status = 1'b1;
            default:                        sync_status = 1'b0;
        endcase
    end

    // One-cycle data pipeline to the PCS.
    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            cg_q   <= '0;
            ctrl_q <= 1'b0;
            inv_q  <= 1'b0;
        end else begin
            cg_q   <= rx.i8_RxCodeGroup;
            ctrl_q <= rx.i_RxCodeCtrl;
            inv_q  <= rx.i_RxCodeInvalid;
        end
    end

    assign rx.o8_RxCodeGroup  = cg_q;
    assign rx.o_RxCodeCtrl    = ctrl_q;
    assign rx.o_RxCodeInvalid = inv_q;
    assign rx.o_RxEven        = even_q;
    assign rx.o_SyncStatus    = sync_status;
    assign rx.o_RxBitSlip     = slip_pulse;
    assign rx.o4_SlipCnt      = slip_cnt;

endmodule
